// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped read-only cache.
// The address splits as {tag, index, offset}, word addressed.
package cache_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int INDEX_W     = 10;
  localparam int OFFSET_W    = 2;
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_WORDS = 1 << OFFSET_W;
  localparam int NUM_LINES   = 1 << INDEX_W;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [DATA_W-1:0]   word_t;
  typedef word_t [BLOCK_WORDS-1:0] block_t;

  typedef struct packed {
    logic   valid;
    tag_t   tag;
    block_t words;
  } line_t;

  function automatic addr_t block_base(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for every cache line: one combinational read port,
// one fill port, and valid bits that clear asynchronously on reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t rd_index,
  output line_t  rd_line,
  input  logic   fill_en,
  input  index_t fill_index,
  input  tag_t   fill_tag,
  input  block_t fill_words
);

  logic [NUM_LINES-1:0] valid_reg;
  tag_t                 tag_mem  [NUM_LINES];
  block_t               data_mem [NUM_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else if (fill_en) begin
      valid_reg[fill_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_words;
    end
  end

  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_reg[rd_index];
    rd_line.tag   = tag_mem[rd_index];
    rd_line.words = data_mem[rd_index];
  end

endmodule

// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache with same-cycle miss forwarding from a
// combinational main memory, plus saturating hit and access counters.
module direct_mapped_cache
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mm_data0,
  input  logic [DATA_W-1:0] mm_data1,
  input  logic [DATA_W-1:0] mm_data2,
  input  logic [DATA_W-1:0] mm_data3,
  output logic [ADDR_W-1:0] mm_address,
  output logic [DATA_W-1:0] data_out,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  tag_t    tag;
  index_t  index;
  offset_t offset;
  block_t  mm_block;
  line_t   line;

  logic [CNT_W-1:0] hit_count_reg;
  logic [CNT_W-1:0] hit_count_next;
  logic [CNT_W-1:0] access_count_reg;
  logic [CNT_W-1:0] access_count_next;

  assign tag    = address[ADDR_W-1 -: TAG_W];
  assign index  = address[OFFSET_W +: INDEX_W];
  assign offset = address[OFFSET_W-1:0];

  assign mm_block   = {mm_data3, mm_data2, mm_data1, mm_data0};
  assign mm_address = block_base(tag, index);

  cache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index),
    .rd_line    (line),
    .fill_en    (!hit),
    .fill_index (index),
    .fill_tag   (tag),
    .fill_words (mm_block)
  );

  assign hit      = line.valid && (line.tag == tag);
  assign data_out = hit ? line.words[offset] : mm_block[offset];

  // Both counters stick at all-ones rather than wrapping, so long runs still read sanely.
  always_comb begin
    access_count_next = access_count_reg;
    hit_count_next    = hit_count_reg;
    if (access_count_reg != '1) begin
      access_count_next = access_count_reg + 1'b1;
    end
    if (hit && (hit_count_reg != '1)) begin
      hit_count_next = hit_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_count_reg <= '0;
      hit_count_reg    <= '0;
    end else begin
      access_count_reg <= access_count_next;
      hit_count_reg    <= hit_count_next;
    end
  end

  assign hit_count    = hit_count_reg;
  assign access_count = access_count_reg;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench for direct_mapped_cache: directed vector table, reset
// corner cases, a sequential sweep and random traffic against a block-level model.
module tb_direct_mapped_cache;

  logic        clk;
  logic        rst;
  logic [14:0] address;
  logic [31:0] mm_data0, mm_data1, mm_data2, mm_data3;
  logic [14:0] mm_address;
  logic [31:0] data_out;
  logic        hit;
  logic [15:0] hit_count;
  logic [15:0] access_count;

  int tests_run;
  int tests_failed;

  // Reference model: which memory block number each line holds (-1 = empty).
  int model_blk [1024];
  int model_acc;
  int model_hits;

  direct_mapped_cache dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .mm_data0     (mm_data0),
    .mm_data1     (mm_data1),
    .mm_data2     (mm_data2),
    .mm_data3     (mm_data3),
    .mm_address   (mm_address),
    .data_out     (data_out),
    .hit          (hit),
    .hit_count    (hit_count),
    .access_count (access_count)
  );

  // Main memory: mem[a] = a.
  assign mm_data0 = 32'(mm_address) + 32'd0;
  assign mm_data1 = 32'(mm_address) + 32'd1;
  assign mm_data2 = 32'(mm_address) + 32'd2;
  assign mm_data3 = 32'(mm_address) + 32'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    bit          exp_hit;
    logic [31:0] exp_data;
    logic [14:0] exp_mm;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input string what, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s %s: got %0d, expected %0d", nm, what, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [14:0] a);
    return model_blk[int'(a[11:2])] == int'(a[14:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model_blk[i] = -1;
    model_acc  = 0;
    model_hits = 0;
  endtask

  task automatic model_commit(input logic [14:0] a);
    model_acc++;
    if (model_hit(a)) model_hits++;
    else model_blk[int'(a[11:2])] = int'(a[14:2]);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply(input logic [14:0] a, input bit exp_hit, input logic [31:0] exp_data,
                       input logic [14:0] exp_mm, input string nm);
    address = a;
    #1;
    chk(nm, "hit", longint'(hit), longint'(exp_hit));
    chk(nm, "data_out", longint'(data_out), longint'(exp_data));
    chk(nm, "mm_address", longint'(mm_address), longint'(exp_mm));
    @(posedge clk);
    model_commit(a);
    @(negedge clk);
  endtask

  task automatic apply_model(input logic [14:0] a, input string nm);
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    apply(a, model_hit(a), 32'(a), base, nm);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    chk("reset", "hit", longint'(hit), 0);
    chk("reset", "hit_count", longint'(hit_count), 0);
    chk("reset", "access_count", longint'(access_count), 0);
    chk("reset", "data_out", longint'(data_out), longint'(address));
    chk("reset", "mm_address", longint'(mm_address), longint'({address[14:2], 2'b00}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b0;
    address = 15'd1024;
    model_clear();

    vecs[0]  = '{15'd1024,  1'b0, 32'd1024,  15'd1024,  "first_miss"};
    vecs[1]  = '{15'd1025,  1'b1, 32'd1025,  15'd1024,  "next_word_hit"};
    vecs[2]  = '{15'd0,     1'b0, 32'd0,     15'd0,     "conflict_a"};
    vecs[3]  = '{15'd4096,  1'b0, 32'd4096,  15'd4096,  "conflict_b"};
    vecs[4]  = '{15'd0,     1'b0, 32'd0,     15'd0,     "conflict_a_again"};
    vecs[5]  = '{15'd32,    1'b0, 32'd32,    15'd32,    "refill_32"};
    vecs[6]  = '{15'd33,    1'b1, 32'd33,    15'd32,    "reread_33"};
    vecs[7]  = '{15'd34,    1'b1, 32'd34,    15'd32,    "reread_34"};
    vecs[8]  = '{15'd35,    1'b1, 32'd35,    15'd32,    "reread_35"};
    vecs[9]  = '{15'd32,    1'b1, 32'd32,    15'd32,    "reread_32"};
    vecs[10] = '{15'd32767, 1'b0, 32'd32767, 15'd32764, "top_miss"};
    vecs[11] = '{15'd32764, 1'b1, 32'd32764, 15'd32764, "top_hit"};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_mm, vecs[i].name);
    end
    chk("table", "access_count", longint'(access_count), 12);
    chk("table", "hit_count", longint'(hit_count), 6);

    // Asynchronous reset between edges discards the line holding block 1024.
    apply(15'd1024, 1'b1, 32'd1024, 15'd1024, "pre_reset_hit");
    rst = 1'b0;
    #1;
    model_clear();
    chk("mid_reset", "access_count", longint'(access_count), 0);
    chk("mid_reset", "hit_count", longint'(hit_count), 0);
    chk("mid_reset", "hit", longint'(hit), 0);
    #1;
    rst = 1'b1;
    apply(15'd1025, 1'b0, 32'd1025, 15'd1024, "post_reset_miss");
    apply(15'd1025, 1'b1, 32'd1025, 15'd1024, "post_reset_refilled");
    chk("post_reset", "access_count", longint'(access_count), 2);
    chk("post_reset", "hit_count", longint'(hit_count), 1);

    // Sequential sweep: one miss per 4-word block.
    do_reset();
    for (int a = 1024; a <= 9215; a++) begin
      apply_model(15'(a), "sweep");
    end
    chk("sweep", "access_count", longint'(access_count), 8192);
    chk("sweep", "hit_count", longint'(hit_count), 6144);

    // Random traffic, mostly inside a small window so hits and conflicts both occur.
    for (int n = 0; n < 3000; n++) begin
      logic [14:0] a;
      if ($urandom_range(0, 3) == 0) a = 15'($urandom_range(0, 32767));
      else a = 15'({$urandom_range(0, 7), 12'd0} + $urandom_range(0, 63));
      apply_model(a, "random");
    end
    chk("random", "access_count", longint'(access_count), longint'(model_acc));
    chk("random", "hit_count", longint'(hit_count), longint'(model_hits));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Read-only, direct-mapped data cache between a 15-bit word-addressed requester and a combinational main memory.
- The main memory returns a full 4-word block for any block-aligned address.
- Hit/miss is resolved combinationally. On a miss the requested word is forwarded from memory in the same cycle, and the line is filled at the next rising clock edge.
- Hit and access counters are kept for hit-rate measurement.

Parameters:
- ADDR_W, 15, word address width (32K words).
- DATA_W, 32, word width.
- INDEX_W, 10, line index width (1024 lines).
- OFFSET_W, 2, word-in-block offset width (4 words per block).
- CNT_W, 16, width of the hit and access counters.
- Derived: TAG_W = ADDR_W - INDEX_W - OFFSET_W = 3.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  reset, active-low, asynchronous.
- address  in  ADDR_W  requested word address; held stable across the rising edge.
- mm_data0..mm_data3  in  DATA_W each  block words 0..3 from main memory for mm_address.
- mm_address  out  ADDR_W  block-aligned address sent to main memory.
- data_out  out  DATA_W  word at address.
- hit  out  1  high when address hits a valid line.
- hit_count  out  CNT_W  number of hit accesses since reset.
- access_count  out  CNT_W  number of accesses since reset.

Interface rule (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Address split:
  - tag = address[14:12]
  - index = address[11:2]
  - offset = address[1:0]
- Storage per line: valid bit, TAG_W tag, 4 x DATA_W words. Use a register array; no byte enables.
- mm_address = {tag, index, 2'b00}. Combinational, always driven, independent of hit.
- hit = valid[index] && (stored_tag[index] == tag). Combinational.
- data_out, combinational:
  - on hit: the cached word selected by offset;
  - on miss: mm_data[offset], forwarded in the same cycle.
  - data_out is therefore always correct in the same cycle, with zero wait states.
- Rising edge with rst high:
  - access_count increments by 1, saturating at all-ones.
  - If hit is high: hit_count increments by 1, saturating; line contents unchanged.
  - If hit is low: line[index] is loaded with mm_data0..3, its tag is set to tag, and valid is set to 1.
  - The same address on the following cycle therefore hits.
- Reset (rst=0, asynchronous):
  - All valid bits are cleared.
  - hit_count and access_count are cleared to 0.
  - Tag and data arrays are not required to clear.
  - Outputs during reset: hit=0; data_out = forwarded memory word; mm_address follows address.
  - Reset asserted mid-run discards all contents, so the next access after release misses.
- Conflict handling: a miss to an index holding another tag overwrites that line (no associativity, no write-back).
- Main memory contract:
  - Combinational read.
  - mm_dataK = memory word at mm_address + K.
  - Valid for any mm_address whose low OFFSET_W bits are 0.
  - Reference content for verification: mem[a] = a, zero-extended to 32 bits.
- X-safety: an unknown address before the first stimulus must not corrupt state. No edge occurs before the first valid address.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W;
  - typedef tag_t, index_t, word_t;
  - typedef line_t (a struct of valid, tag, and a 4-word array).
- One natural sub-module, cache_line_array: the valid/tag/data storage, with a combinational read port, a single fill port, and async valid clear.
- Top-level logic: address split, hit compare, output mux, counters.
- main_memory_model is a separate verification-only module, not part of this block.

Test Plan:
- Reset, then single read of 1024: hit=0, mm_address=1024, data_out=1024. Next cycle reading 1025: hit=1, data_out=1025.
- Sequential sweep 1024..9215, one per cycle: every address with offset 0 misses, the others hit. Final access_count=8192, hit_count=6144 (75%).
- Conflict: read 0, then 4096 (same index 0, tag 1), then 0. All three miss, data_out = 0, 4096, 0; hit_count stays 0.
- Re-read after fill: read 32 (miss), then 33, 34, 35, 32: all hit with data equal to the address; mm_address stays 32.
- Reset mid-sweep: after filling block 1024, pulse rst low between clock edges. Counters read 0 immediately (asynchronously); the next read of 1025 misses and refills.
- Boundary: read 32767 (tag 7, index 1023, offset 3): miss, mm_address=32764, data_out=32767. Next cycle read 32764: hit.
